// File: rtl/seg_serial_driver.sv
// Seven-segment serial driver: snapshots a 32-bit debug word,
// encodes 8 hex digits and shifts a 64-bit frame into the board chain.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   data       8 hex digits, digit7 = data[31:28]
//   point      per-digit decimal point enable
//   les        per-digit blink enable
//   blink      blink phase, blanks digits with les set
//   seg_clk    serial shift clock
//   seg_do     serial data, frame MSB first
//   seg_pen    latch strobe after the last bit
//   seg_clr    chain clear, active low
//   busy       high in LOAD, SHIFT and LATCH
//   frame_done one-cycle pulse on the last LATCH cycle

module seg_serial_driver #(
   parameter int CLK_DIV = 4,
   parameter int GAP     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data,
   input  logic [7:0]  point,
   input  logic [7:0]  les,
   input  logic        blink,
   output logic        seg_clk,
   output logic        seg_do,
   output logic        seg_pen,
   output logic        seg_clr,
   output logic        busy,
   output logic        frame_done
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
   localparam logic          DIV_ONE  = (CLK_DIV == 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_LATCH
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_gap;
   logic [DW-1:0]   r_div;
   logic [5:0]      r_idx;
   logic [63:0]     r_frame;
   logic [63:0]     w_frame;

   // Active-low segment pattern {g,f,e,d,c,b,a}
   function automatic logic [6:0] f_seg(
      input logic [3:0] n
   );
      logic [6:0] s;
      s = 7'h7F;
      unique case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Blanking wins over the decimal point
   always_comb begin
      w_frame = '0;
      for (int i = 0; i < 8; i++) begin
         if (les[i] && blink)
            w_frame[i*8 +: 8] = 8'hFF;
         else
            w_frame[i*8 +: 8] =
               {~point[i], f_seg(data[i*4 +: 4])};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_gap      <= '0;
         r_div      <= '0;
         r_idx      <= '0;
         r_frame    <= '0;
         seg_clk    <= 1'b0;
         seg_do     <= 1'b0;
         seg_pen    <= 1'b0;
         seg_clr    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         seg_clr    <= 1'b1;
         frame_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (r_gap == GAP_LAST) begin
                  r_gap   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_LOAD;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            // Frame register is the per-frame snapshot;
            // the first bit is presented as SHIFT begins.
            S_LOAD: begin
               r_frame <= w_frame;
               r_idx   <= 6'd63;
               r_div   <= '0;
               seg_clk <= 1'b0;
               seg_do  <= w_frame[63];
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (r_div != DIV_LAST) begin
                  r_div <= r_div + DW'(1);
               end else begin
                  r_div <= '0;
                  if (!seg_clk) begin
                     seg_clk <= 1'b1;
                  end else begin
                     seg_clk <= 1'b0;
                     if (r_idx == 6'd0) begin
                        seg_do     <= 1'b0;
                        seg_pen    <= 1'b1;
                        frame_done <= DIV_ONE;
                        r_state    <= S_LATCH;
                     end else begin
                        r_idx   <= r_idx - 6'd1;
                        r_frame <= {r_frame[62:0], 1'b0};
                        seg_do  <= r_frame[62];
                     end
                  end
               end
            end
            S_LATCH: begin
               if (r_div == DIV_LAST) begin
                  r_div   <= '0;
                  seg_pen <= 1'b0;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_div      <= r_div + DW'(1);
                  frame_done <= ((r_div + DW'(1)) == DIV_LAST);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Directed bench for seg_serial_driver: default instance (A)
// plus a CLK_DIV=1, GAP=1 instance (B) sharing all inputs.

`define CHK(tag, obs, exp) \
   begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
         errors++; \
         $error("FAIL %s obs=%0h exp=%0h", \
                tag, (obs), (exp)); \
      end \
   end

module tb_seg_serial_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] data;
   logic [7:0]  point;
   logic [7:0]  les;
   logic        blink;

   logic a_clk, a_do, a_pen, a_clr, a_busy, a_fd;
   logic b_clk, b_do, b_pen, b_clr, b_busy, b_fd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg_serial_driver #(.CLK_DIV(4), .GAP(16)) u_a (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .point      (point),
      .les        (les),
      .blink      (blink),
      .seg_clk    (a_clk),
      .seg_do     (a_do),
      .seg_pen    (a_pen),
      .seg_clr    (a_clr),
      .busy       (a_busy),
      .frame_done (a_fd)
   );

   seg_serial_driver #(.CLK_DIV(1), .GAP(1)) u_b (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .point      (point),
      .les        (les),
      .blink      (blink),
      .seg_clk    (b_clk),
      .seg_do     (b_do),
      .seg_pen    (b_pen),
      .seg_clr    (b_clr),
      .busy       (b_busy),
      .frame_done (b_fd)
   );

   function automatic logic bsy(input bit s);
      return s ? b_busy : a_busy;
   endfunction

   function automatic logic sck(input bit s);
      return s ? b_clk : a_clk;
   endfunction

   function automatic logic sdo(input bit s);
      return s ? b_do : a_do;
   endfunction

   function automatic logic spen(input bit s);
      return s ? b_pen : a_pen;
   endfunction

   function automatic logic sfd(input bit s);
      return s ? b_fd : a_fd;
   endfunction

   // Wait until the next LOAD cycle (busy rising)
   task automatic wait_load(input bit s, output int to);
      int n;
      to = 0;
      n  = 0;
      while (bsy(s) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      while (!bsy(s) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!bsy(s)) to = 1;
   endtask

   // Called in a LOAD cycle; follows the frame until busy drops
   task automatic cap(
      input  bit          s,
      output logic [63:0] fr,
      output int          nb,
      output int          pl,
      output int          fdn,
      output int          fdat,
      output int          bl,
      output int          hi,
      output int          bad,
      output int          to
   );
      logic pc;
      logic pd;
      fr = '0;
      nb = 0; pl = 0; fdn = 0; fdat = 0;
      bl = 0; hi = 0; bad = 0; to = 0;
      pc = sck(s);
      pd = sdo(s);
      while (bsy(s) && bl < 2000) begin
         bl++;
         if (!pc && sck(s)) begin
            fr = {fr[62:0], sdo(s)};
            nb++;
         end
         if (sck(s)) hi++;
         if (pc && sck(s) && sdo(s) != pd) bad++;
         if (spen(s) && (sdo(s) || sck(s))) bad++;
         if (spen(s)) pl++;
         if (sfd(s)) begin
            fdn++;
            fdat = pl;
         end
         pc = sck(s);
         pd = sdo(s);
         @(negedge clk);
      end
      if (bl >= 2000) to = 1;
   endtask

   task automatic gap_len(input bit s, output int g);
      g = 0;
      while (!bsy(s) && g < 1000) begin
         @(negedge clk);
         g++;
      end
   endtask

   logic [63:0] fr;
   int nb, pl, fdn, fdat, bl, hi, bad, to;
   int g, k, rises, pen_seen;

   initial begin
      data  = 32'h0123_4567;
      point = 8'h00;
      les   = 8'h00;
      blink = 1'b0;

      // T1 reset
      repeat (3) @(negedge clk);
      `CHK("rst_a_outs",
           {a_clk, a_do, a_pen, a_clr, a_busy, a_fd}, 6'b0)
      `CHK("rst_b_outs",
           {b_clk, b_do, b_pen, b_clr, b_busy, b_fd}, 6'b0)
      rst = 1'b1;
      @(negedge clk);
      k = 1;
      `CHK("clr_after_rel", a_clr, 1'b1)
      `CHK("a_idle_k1", a_busy, 1'b0)
      `CHK("b_load_k1", b_busy, 1'b1)
      while (!a_busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      `CHK("first_load_edges", k, 16)

      // T2 digits 0..7
      cap(1'b0, fr, nb, pl, fdn, fdat, bl, hi, bad, to);
      `CHK("t2_to", to, 0)
      `CHK("t2_frame", fr, 64'hC0F9A4B0_999282F8)
      `CHK("t2_bits", nb, 64)
      `CHK("t2_pen_len", pl, 4)
      `CHK("t2_done_cnt", fdn, 1)
      `CHK("t2_done_pos", fdat, 4)
      `CHK("t2_busy_len", bl, 517)
      `CHK("t2_hi_cycles", hi, 256)
      `CHK("t2_bad", bad, 0)

      // T3 digits 8..F, dp on digit 0
      data  = 32'h89AB_CDEF;
      point = 8'h01;
      gap_len(1'b0, g);
      `CHK("t2_gap", g, 16)
      cap(1'b0, fr, nb, pl, fdn, fdat, bl, hi, bad, to);
      `CHK("t3_to", to, 0)
      `CHK("t3_frame", fr, 64'h80908883_C6A1860E)
      `CHK("t3_bits", nb, 64)
      `CHK("t3_bad", bad, 0)

      // T4 blink upper digits, toggle blink mid-frame
      data  = 32'hFFFF_FFFF;
      point = 8'h00;
      les   = 8'hF0;
      blink = 1'b1;
      gap_len(1'b0, g);
      `CHK("t3_gap", g, 16)
      fork
         cap(1'b0, fr, nb, pl, fdn, fdat, bl, hi, bad, to);
         begin
            repeat (100) @(negedge clk);
            blink = 1'b0;
         end
      join
      `CHK("t4_to", to, 0)
      `CHK("t4_frame", fr, 64'hFFFFFFFF_8E8E8E8E)
      gap_len(1'b0, g);
      cap(1'b0, fr, nb, pl, fdn, fdat, bl, hi, bad, to);
      `CHK("t4b_to", to, 0)
      `CHK("t4b_frame", fr, 64'h8E8E8E8E_8E8E8E8E)

      // T5 reset during bit 30
      data  = 32'h0123_4567;
      les   = 8'h00;
      gap_len(1'b0, g);
      rises    = 0;
      pen_seen = 0;
      k        = 0;
      while (rises < 33 && k < 2000) begin
         @(negedge clk);
         k++;
         if (a_clk) rises++;
         while (a_clk && k < 2000) begin
            @(negedge clk);
            k++;
         end
         if (a_pen) pen_seen++;
      end
      `CHK("t5_reach_bit30", rises, 33)
      `CHK("t5_clk_low", a_clk, 1'b0)
      #2 rst = 1'b0;
      #1;
      `CHK("t5_async_a",
           {a_clk, a_do, a_pen, a_clr, a_busy, a_fd}, 6'b0)
      `CHK("t5_async_b",
           {b_clk, b_do, b_pen, b_clr, b_busy, b_fd}, 6'b0)
      repeat (3) begin
         @(negedge clk);
         if (a_pen) pen_seen++;
      end
      rst = 1'b1;
      k = 0;
      while (!a_busy && k < 100) begin
         @(negedge clk);
         k++;
         if (a_pen) pen_seen++;
      end
      `CHK("t5_no_pen", pen_seen, 0)
      `CHK("t5_reload_edges", k, 16)
      cap(1'b0, fr, nb, pl, fdn, fdat, bl, hi, bad, to);
      `CHK("t5_to", to, 0)
      `CHK("t5_frame", fr, 64'hC0F9A4B0_999282F8)
      `CHK("t5_bits", nb, 64)
      `CHK("t5_pen_len", pl, 4)

      // T6 CLK_DIV=1, GAP=1 instance
      wait_load(1'b1, to);
      `CHK("t6_wait_to", to, 0)
      cap(1'b1, fr, nb, pl, fdn, fdat, bl, hi, bad, to);
      `CHK("t6_to", to, 0)
      `CHK("t6_frame", fr, 64'hC0F9A4B0_999282F8)
      `CHK("t6_bits", nb, 64)
      `CHK("t6_pen_len", pl, 1)
      `CHK("t6_done_pos", fdat, 1)
      `CHK("t6_busy_len", bl, 130)
      `CHK("t6_hi_cycles", hi, 64)
      `CHK("t6_bad", bad, 0)
      gap_len(1'b1, g);
      `CHK("t6_period", bl + g, 131)

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
